// File: rtl/lc3_bus_pkg.sv
// lc3_bus_pkg: shared state type, source indices and defaults for the LC-3 bus arbiter
package lc3_bus_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, FAULT} bus_state_e;
  localparam int SRC_MARMUX = 0;
  localparam int SRC_PC = 1;
  localparam int SRC_ALU = 2;
  localparam int SRC_MDR = 3;
  localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/lc3_bus_prio_enc.sv
// lc3_bus_prio_enc: lowest-index gate finder with any/multiple-gate flags
module lc3_bus_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM_SRC-1:0] gate,
  output logic [IDX_W-1:0]   idx,
  output logic               any,
  output logic               multi
);
  // scan downward so the lowest set index is the last one written
  always_comb begin
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (gate[i]) idx = IDX_W'(i);
  end
  assign any = |gate;
  assign multi = (gate & (gate - NUM_SRC'(1))) != '0;
endmodule

// File: rtl/lc3_bus_arbiter.sv
// lc3_bus_arbiter: gates one of NUM_SRC sources onto the registered datapath bus with conflict tracking
module lc3_bus_arbiter
  import lc3_bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_SRC = 4,
  parameter int STRICT = 0,
  parameter int HOLD = 1,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0,
  parameter logic [WIDTH-1:0] FAULT_VAL = WIDTH'(16'hDEAD),
  parameter int CNT_W = 8,
  localparam int IDX_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_n,
  input  logic [NUM_SRC-1:0]       i_Gate,
  input  logic [NUM_SRC*WIDTH-1:0] i_Src,
  input  logic                     i_Conflict_Clr,
  output logic [WIDTH-1:0]         o_Bus,
  output logic                     o_Bus_Valid,
  output logic [IDX_W-1:0]         o_Bus_Owner,
  output logic                     o_Conflict,
  output logic                     o_Conflict_Sticky,
  output logic [CNT_W-1:0]         o_Conflict_Count
);
  bus_state_e state, state_nx;
  logic [IDX_W-1:0] idx;
  logic any, multi, locked;
  logic [WIDTH-1:0] bus_nx;
  logic [WIDTH-1:0] src [NUM_SRC];
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign src[k] = i_Src[k*WIDTH +: WIDTH];
  end
  lc3_bus_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_enc (
    .gate  (i_Gate),
    .idx   (idx),
    .any   (any),
    .multi (multi)
  );
  assign locked = state == FAULT && !i_Conflict_Clr;
  // next state and next bus value; a clear releases FAULT so the same edge is evaluated normally
  always_comb begin
    state_nx = locked ? FAULT : !any ? IDLE : (multi && STRICT != 0) ? FAULT : DRIVE;
    bus_nx = state_nx == FAULT ? FAULT_VAL : state_nx == DRIVE ? src[idx] : HOLD != 0 ? o_Bus : IDLE_VAL;
  end
  // state register
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) state <= IDLE;
    else state <= state_nx;
  // bus outputs and conflict bookkeeping; a conflict overrides a same-edge clear
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      o_Bus <= IDLE_VAL;
      o_Bus_Valid <= 1'b0;
      o_Bus_Owner <= '0;
      o_Conflict <= 1'b0;
      o_Conflict_Sticky <= 1'b0;
      o_Conflict_Count <= '0;
    end else begin
      o_Bus <= bus_nx;
      o_Bus_Valid <= state_nx == DRIVE;
      if (state_nx == DRIVE) o_Bus_Owner <= idx;
      o_Conflict <= multi;
      if (multi) o_Conflict_Sticky <= 1'b1;
      else if (i_Conflict_Clr) o_Conflict_Sticky <= 1'b0;
      if (multi) o_Conflict_Count <= i_Conflict_Clr ? CNT_W'(1) : &o_Conflict_Count ? o_Conflict_Count : o_Conflict_Count + CNT_W'(1);
      else if (i_Conflict_Clr) o_Conflict_Count <= '0;
    end
endmodule

// File: tb/tb_lc3_bus_arbiter.sv
// tb_lc3_bus_arbiter: random and directed checks of two arbiter configurations against a behavioural model
module tb_lc3_bus_arbiter;
  logic clk = 0, rst_n = 0, clr = 0;
  logic [3:0] gate = 0;
  logic [63:0] src = 0;
  logic [15:0] a_bus, b_bus;
  logic a_valid, b_valid, a_conf, b_conf, a_sticky, b_sticky;
  logic [1:0] a_owner, b_owner, a_cnt;
  logic [7:0] b_cnt;
  int checks = 0, failures = 0;
  bit strict_p [2] = '{0, 1};
  bit hold_p [2] = '{1, 0};
  int cnt_max [2] = '{3, 255};
  logic [15:0] m_bus [2];
  bit m_valid [2], m_conf [2], m_sticky [2], m_fault [2];
  int m_owner [2], m_cnt [2];

  always #5 clk = ~clk;

  lc3_bus_arbiter #(.STRICT(0), .HOLD(1), .CNT_W(2)) dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Gate(gate), .i_Src(src), .i_Conflict_Clr(clr),
    .o_Bus(a_bus), .o_Bus_Valid(a_valid), .o_Bus_Owner(a_owner), .o_Conflict(a_conf),
    .o_Conflict_Sticky(a_sticky), .o_Conflict_Count(a_cnt));

  lc3_bus_arbiter #(.STRICT(1), .HOLD(0), .CNT_W(8)) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Gate(gate), .i_Src(src), .i_Conflict_Clr(clr),
    .o_Bus(b_bus), .o_Bus_Valid(b_valid), .o_Bus_Owner(b_owner), .o_Conflict(b_conf),
    .o_Conflict_Sticky(b_sticky), .o_Conflict_Count(b_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_bus[k] = 0; m_valid[k] = 0; m_owner[k] = 0; m_conf[k] = 0;
      m_sticky[k] = 0; m_cnt[k] = 0; m_fault[k] = 0;
    end
  endtask

  task automatic model_step();
    int g, low;
    g = $countones(gate);
    low = 0;
    for (int i = 3; i >= 0; i--) if (gate[i]) low = i;
    for (int k = 0; k < 2; k++) begin
      if (m_fault[k] && !clr) begin
        m_bus[k] = 16'hDEAD; m_valid[k] = 0;
      end else if (g == 0) begin
        m_fault[k] = 0; m_valid[k] = 0;
        if (!hold_p[k]) m_bus[k] = 0;
      end else if (g > 1 && strict_p[k]) begin
        m_fault[k] = 1; m_bus[k] = 16'hDEAD; m_valid[k] = 0;
      end else begin
        m_fault[k] = 0; m_bus[k] = src[low*16 +: 16]; m_valid[k] = 1; m_owner[k] = low;
      end
      m_conf[k] = g > 1;
      if (g > 1) begin
        m_sticky[k] = 1;
        m_cnt[k] = clr ? 1 : (m_cnt[k] < cnt_max[k] ? m_cnt[k] + 1 : cnt_max[k]);
      end else if (clr) begin
        m_sticky[k] = 0; m_cnt[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("a_bus", 32'(a_bus), 32'(m_bus[0]));
    chk("a_valid", 32'(a_valid), 32'(m_valid[0]));
    chk("a_owner", 32'(a_owner), 32'(m_owner[0]));
    chk("a_conf", 32'(a_conf), 32'(m_conf[0]));
    chk("a_sticky", 32'(a_sticky), 32'(m_sticky[0]));
    chk("a_cnt", 32'(a_cnt), 32'(m_cnt[0]));
    chk("b_bus", 32'(b_bus), 32'(m_bus[1]));
    chk("b_valid", 32'(b_valid), 32'(m_valid[1]));
    chk("b_owner", 32'(b_owner), 32'(m_owner[1]));
    chk("b_conf", 32'(b_conf), 32'(m_conf[1]));
    chk("b_sticky", 32'(b_sticky), 32'(m_sticky[1]));
    chk("b_cnt", 32'(b_cnt), 32'(m_cnt[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1;
    // async reset dropping an in-flight ALU transfer
    gate = 4'b0100; src[32 +: 16] = 16'h1234;
    tick();
    chk("t1_bus_before", 32'(a_bus), 32'h1234);
    #2 rst_n = 0;
    #1;
    chk("t1_rst_bus", 32'(a_bus), 32'h0);
    chk("t1_rst_valid", 32'(a_valid), 32'h0);
    chk("t1_rst_cnt", 32'(b_cnt), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    compare_all();
    // single gate
    gate = 4'b0010; src[16 +: 16] = 16'h3000;
    tick();
    chk("t2_bus", 32'(a_bus), 32'h3000);
    chk("t2_valid", 32'(a_valid), 32'h1);
    chk("t2_owner", 32'(a_owner), 32'h1);
    chk("t2_conf", 32'(a_conf), 32'h0);
    // idle: hold versus return to idle value
    gate = 4'b0000;
    tick();
    chk("t3_hold_bus", 32'(a_bus), 32'h3000);
    chk("t3_idle_bus", 32'(b_bus), 32'h0);
    chk("t3_valid", 32'(a_valid), 32'h0);
    // priority conflict
    gate = 4'b1100; src[32 +: 16] = 16'h00AA; src[48 +: 16] = 16'h5555;
    tick();
    chk("t4_bus", 32'(a_bus), 32'h00AA);
    chk("t4_owner", 32'(a_owner), 32'h2);
    chk("t4_conf", 32'(a_conf), 32'h1);
    chk("t4_sticky", 32'(a_sticky), 32'h1);
    chk("t4_cnt", 32'(a_cnt), 32'h1);
    chk("t4_fault_bus", 32'(b_bus), 32'hDEAD);
    gate = 4'b0000;
    tick();
    chk("t4_pulse_end", 32'(a_conf), 32'h0);
    // strict fault lock and release
    gate = 4'b0011;
    tick();
    chk("t5_dead", 32'(b_bus), 32'hDEAD);
    gate = 4'b0100;
    tick();
    chk("t5_locked", 32'(b_bus), 32'hDEAD);
    chk("t5_locked_valid", 32'(b_valid), 32'h0);
    clr = 1;
    tick();
    clr = 0;
    chk("t5_rel_bus", 32'(b_bus), 32'h00AA);
    chk("t5_rel_valid", 32'(b_valid), 32'h1);
    chk("t5_rel_sticky", 32'(b_sticky), 32'h0);
    chk("t5_rel_cnt", 32'(b_cnt), 32'h0);
    // saturation of the 2-bit counter
    gate = 4'b0000; clr = 1;
    tick();
    clr = 0; gate = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_sat", 32'(a_cnt), 32'(exp_cnt[i]));
    end
    clr = 1;
    tick();
    clr = 0;
    chk("t6_clr_conf_cnt", 32'(a_cnt), 32'h1);
    chk("t6_clr_conf_sticky", 32'(a_sticky), 32'h1);
    chk("t6_clr_conf_fault", 32'(b_bus), 32'hDEAD);
    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      gate = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) gate = 4'(1 << $urandom_range(0, 3));
      src = {$urandom, $urandom};
      clr = $urandom_range(0, 9) == 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
